uart_param: RTL and testbench

UART_PARAM -- requirements
Module: uart_param

---
 rtl/uart_param.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// Full-duplex UART with runtime prescale, optional parity and one or two stop bits.
// Optional build macro UART_PARAM_LOOPBACK_EN adds a LOOPBACK input routing TX_OUT into the RX path.
module uart_param #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [DATA_WIDTH-1:0] TX_P_DATA,
    input  logic                  TX_DATA_VALID,
    output logic                  TX_OUT,
    output logic                  Busy,
    input  logic                  RX_IN,
`ifdef UART_PARAM_LOOPBACK_EN
    input  logic                  LOOPBACK,
`endif
    output logic [DATA_WIDTH-1:0] RX_P_DATA,
    output logic                  RX_DATA_VALID,
    output logic                  PAR_Err,
    output logic                  Frame_Err,
    output logic [2:0]            tx_state_o,
    output logic [2:0]            rx_state_o
);

    typedef enum logic [2:0] {IDLE = 3'd0, START, DATA, PARITY, STOP} state_e;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    function automatic logic [5:0] eff_prescale(input logic [5:0] p);
        if (p == 6'd8 || p == 6'd16 || p == 6'd32) return p;
        return 6'd16;
    endfunction

    // ---------------- transmitter ----------------
    state_e                tx_state_q, tx_state_d;
    logic [5:0]            tx_cnt_q, tx_cnt_d, tx_pre_q, tx_pre_d;
    logic [3:0]            tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_stop2_q, tx_stop2_d;
    logic                  tx_last;

    assign tx_last    = (tx_cnt_q == tx_pre_q - 6'd1);
    assign tx_state_o = tx_state_q;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_last ? 6'd0 : tx_cnt_q + 6'd1;
        tx_pre_d    = tx_pre_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_par_en_d = tx_par_en_q;
        tx_stop2_d  = tx_stop2_q;
        TX_OUT      = 1'b1;
        Busy        = 1'b1;
        case (tx_state_q)
            IDLE: begin
                Busy     = 1'b0;
                tx_cnt_d = 6'd0;
                if (TX_DATA_VALID) begin
                    tx_state_d  = START;
                    tx_pre_d    = eff_prescale(Prescale);
                    tx_shift_d  = TX_P_DATA;
                    tx_par_d    = PAR_TYP ^ (^TX_P_DATA);
                    tx_par_en_d = PAR_EN;
                    tx_stop2_d  = STOP2;
                    tx_bit_d    = 4'd0;
                end
            end
            START: begin
                TX_OUT = 1'b0;
                if (tx_last) tx_state_d = DATA;
            end
            DATA: begin
                TX_OUT = tx_shift_q[0];
                if (tx_last) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_bit_d   = 4'd0;
                        tx_state_d = tx_par_en_q ? PARITY : STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                TX_OUT = tx_par_q;
                if (tx_last) tx_state_d = STOP;
            end
            STOP: begin
                if (tx_last) begin
                    if (tx_stop2_q && tx_bit_q == 4'd0) tx_bit_d   = 4'd1;
                    else                                tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic                  rx_src, rx_s1_q, rx_s2_q, rx_s3_q;
    state_e                rx_state_q, rx_state_d;
    logic [5:0]            rx_cnt_q, rx_cnt_d, rx_pre_q, rx_pre_d, rx_half;
    logic [3:0]            rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [1:0]            rx_smp_q, rx_smp_d;
    logic                  rx_par_bit_q, rx_par_bit_d, rx_par_en_q, rx_par_en_d, rx_par_typ_q, rx_par_typ_d;
    logic                  rx_valid_d, rx_perr_d, rx_ferr_d, rx_valid_q, rx_perr_q, rx_ferr_q;
    logic                  rx_last, rx_decide, rx_maj, rx_par_bad;

`ifdef UART_PARAM_LOOPBACK_EN
    assign rx_src = LOOPBACK ? TX_OUT : RX_IN;
`else
    assign rx_src = RX_IN;
`endif

    assign rx_half    = {1'b0, rx_pre_q[5:1]};
    assign rx_last    = (rx_cnt_q == rx_pre_q - 6'd1);
    assign rx_decide  = (rx_cnt_q == rx_half + 6'd1);
    assign rx_maj     = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s2_q) | (rx_smp_q[1] & rx_s2_q);
    assign rx_par_bad = rx_par_en_q & (rx_par_bit_q != (rx_par_typ_q ^ (^rx_shift_q)));

    assign RX_P_DATA     = rx_data_q;
    assign RX_DATA_VALID = rx_valid_q;
    assign PAR_Err       = rx_perr_q;
    assign Frame_Err     = rx_ferr_q;
    assign rx_state_o    = rx_state_q;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_last ? 6'd0 : rx_cnt_q + 6'd1;
        rx_pre_d     = rx_pre_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_smp_d     = rx_smp_q;
        rx_par_bit_d = rx_par_bit_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_typ_d = rx_par_typ_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_perr_d    = 1'b0;
        rx_ferr_d    = 1'b0;
        if (rx_cnt_q == rx_half - 6'd1) rx_smp_d[0] = rx_s2_q;
        if (rx_cnt_q == rx_half)        rx_smp_d[1] = rx_s2_q;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = 6'd0;
                // the edge-detect cycle is count 0 of the start bit
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d   = START;
                    rx_cnt_d     = 6'd1;
                    rx_pre_d     = eff_prescale(Prescale);
                    rx_par_en_d  = PAR_EN;
                    rx_par_typ_d = PAR_TYP;
                    rx_bit_d     = 4'd0;
                end
            end
            START: begin
                if (rx_decide && rx_maj) begin
                    rx_state_d = IDLE;
                    rx_cnt_d   = 6'd0;
                end else if (rx_last) begin
                    rx_state_d = DATA;
                end
            end
            DATA: begin
                if (rx_decide) rx_shift_d = {rx_maj, rx_shift_q[DATA_WIDTH-1:1]};
                if (rx_last) begin
                    if (rx_bit_q == LAST_BIT) begin
                        rx_bit_d   = 4'd0;
                        rx_state_d = rx_par_en_q ? PARITY : STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (rx_decide) rx_par_bit_d = rx_maj;
                if (rx_last)   rx_state_d   = STOP;
            end
            STOP: begin
                if (rx_decide) begin
                    rx_state_d = IDLE;
                    rx_cnt_d   = 6'd0;
                    rx_ferr_d  = ~rx_maj;
                    rx_perr_d  = rx_par_bad;
                    if (rx_maj && !rx_par_bad) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            tx_state_q   <= IDLE;
            tx_cnt_q     <= 6'd0;
            tx_pre_q     <= 6'd16;
            tx_bit_q     <= 4'd0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_par_en_q  <= 1'b0;
            tx_stop2_q   <= 1'b0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_state_q   <= IDLE;
            rx_cnt_q     <= 6'd0;
            rx_pre_q     <= 6'd16;
            rx_bit_q     <= 4'd0;
            rx_shift_q   <= '0;
            rx_smp_q     <= 2'b11;
            rx_par_bit_q <= 1'b0;
            rx_par_en_q  <= 1'b0;
            rx_par_typ_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_pre_q     <= tx_pre_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_stop2_q   <= tx_stop2_d;
            rx_s1_q      <= rx_src;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_pre_q     <= rx_pre_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_smp_q     <= rx_smp_d;
            rx_par_bit_q <= rx_par_bit_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_typ_q <= rx_par_typ_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: 8-bit instance for TX/RX/loopback, 9-bit instance for TX and mid-frame reset.
module tb_uart_param;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [5:0] Prescale;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic [8:0] tx_data;
    logic       valid8, valid9, rx_drive, rx9_drive, loop_sel, rx_in8;

    logic       tx_out8, busy8, rxv8, perr8, ferr8;
    logic [7:0] rx_data8;
    logic [2:0] txs8, rxs8;
    logic       tx_out9, busy9, rxv9, perr9, ferr9;
    logic [8:0] rx_data9;
    logic [2:0] txs9, rxs9;

`ifdef UART_PARAM_LOOPBACK_EN
    assign rx_in8 = rx_drive;
`else
    assign rx_in8 = loop_sel ? tx_out8 : rx_drive;
`endif

    uart_param #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_P_DATA(tx_data[7:0]), .TX_DATA_VALID(valid8), .TX_OUT(tx_out8), .Busy(busy8), .RX_IN(rx_in8),
`ifdef UART_PARAM_LOOPBACK_EN
        .LOOPBACK(loop_sel),
`endif
        .RX_P_DATA(rx_data8), .RX_DATA_VALID(rxv8), .PAR_Err(perr8), .Frame_Err(ferr8),
        .tx_state_o(txs8), .rx_state_o(rxs8)
    );

    uart_param #(.DATA_WIDTH(9)) dut9 (
        .CLK(CLK), .RST(RST), .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_P_DATA(tx_data), .TX_DATA_VALID(valid9), .TX_OUT(tx_out9), .Busy(busy9), .RX_IN(rx9_drive),
`ifdef UART_PARAM_LOOPBACK_EN
        .LOOPBACK(1'b0),
`endif
        .RX_P_DATA(rx_data9), .RX_DATA_VALID(rxv9), .PAR_Err(perr9), .Frame_Err(ferr9),
        .tx_state_o(txs9), .rx_state_o(rxs9)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rxv = 0, n_perr = 0, n_ferr = 0;
    logic       exp_bits[$];
    logic [8:0] exp_q[$];
    logic [7:0] last_good;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic int eff_pre(input logic [5:0] p);
        if (p == 6'd8 || p == 6'd16 || p == 6'd32) return int'(p);
        return 16;
    endfunction

    // Line-level picture of one frame: start, data LSB first, optional parity, stop bit(s).
    task automatic build_frame(input logic [8:0] d, input int dw, input logic pe, input logic pt,
                               input logic s2, input logic bad_par, input logic stop_val);
        int ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) exp_bits.push_back(((ones % 2) == 1) ^ pt ^ bad_par);
        exp_bits.push_back(stop_val);
        if (s2) exp_bits.push_back(1'b1);
    endtask

    function automatic logic [5:0] rand_pre;
        int pick = $urandom_range(0, 3);
        if (pick == 0) return 6'd8;
        if (pick == 1) return 6'd16;
        if (pick == 2) return 6'd32;
        return 6'($urandom_range(0, 63));
    endfunction

    always @(negedge CLK) begin
        if (rxv8 === 1'b1) begin
            n_rxv++;
            if (exp_q.size() > 0) check("rx_data", {24'd0, rx_data8}, {23'd0, exp_q.pop_front()});
            else                  check("rx_unexpected_valid", {31'd0, rxv8}, 32'd0);
        end
        if (perr8 === 1'b1) n_perr++;
        if (ferr8 === 1'b1) n_ferr++;
    end

    task automatic tx_frame(input bit is9, input logic [8:0] d, input logic pe, input logic pt,
                            input logic s2, input logic [5:0] pre);
        int p  = eff_pre(pre);
        int dw = is9 ? 9 : 8;
        build_frame(d, dw, pe, pt, s2, 1'b0, 1'b1);
        Prescale = pre; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; tx_data = d;
        if (is9) valid9 = 1'b1; else valid8 = 1'b1;
        tick;
        for (int i = 0; i < exp_bits.size() * p; i++) begin
            check("tx_out", {31'd0, is9 ? tx_out9 : tx_out8}, {31'd0, exp_bits[i / p]});
            check("tx_busy", {31'd0, is9 ? busy9 : busy8}, 32'd1);
            // requests and input changes while busy must not disturb the frame
            if (is9) valid9 = 1'($urandom_range(0, 1)); else valid8 = 1'($urandom_range(0, 1));
            tx_data = 9'($urandom);
            PAR_EN  = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
            STOP2   = 1'($urandom_range(0, 1));
            tick;
        end
        valid8 = 1'b0; valid9 = 1'b0;
        check("tx_busy_end", {31'd0, is9 ? busy9 : busy8}, 32'd0);
        check("tx_idle_line", {31'd0, is9 ? tx_out9 : tx_out8}, 32'd1);
        tick;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] pre,
                            input logic bad_par, input logic stop_val);
        int   p  = eff_pre(pre);
        int   v0 = n_rxv, pe0 = n_perr, fe0 = n_ferr;
        logic good = stop_val && !(pe && bad_par);
        build_frame({1'b0, d}, 8, pe, pt, 1'b0, bad_par, stop_val);
        Prescale = pre; PAR_EN = pe; PAR_TYP = pt;
        if (good) begin
            exp_q.push_back({1'b0, d});
            last_good = d;
        end
        for (int b = 0; b < exp_bits.size(); b++) begin
            rx_drive = exp_bits[b];
            repeat (p) tick;
        end
        rx_drive = 1'b1;
        repeat (10) tick;
        check("rx_valid_count", n_rxv - v0, {31'd0, good});
        check("rx_perr_count", n_perr - pe0, {31'd0, pe && bad_par});
        check("rx_ferr_count", n_ferr - fe0, {31'd0, !stop_val});
        check("rx_data_hold", {24'd0, rx_data8}, {24'd0, last_good});
        check("rx_scoreboard_drained", exp_q.size(), 32'd0);
        check("rx_back_idle", {29'd0, rxs8}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, k;
        RST = 1'b0; Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        tx_data = '0; valid8 = 1'b0; valid9 = 1'b0; rx_drive = 1'b1; rx9_drive = 1'b1;
        loop_sel = 1'b0; last_good = 8'h00;
        repeat (3) tick;

        check("rst_tx_out", {31'd0, tx_out8}, 32'd1);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data8}, 32'd0);
        check("rst_rx_valid", {31'd0, rxv8}, 32'd0);
        check("rst_par_err", {31'd0, perr8}, 32'd0);
        check("rst_frame_err", {31'd0, ferr8}, 32'd0);
        check("rst_tx_state", {29'd0, txs8}, 32'd0);
        check("rst_rx_state", {29'd0, rxs8}, 32'd0);
        check("rst_tx_out9", {31'd0, tx_out9}, 32'd1);
        check("rst_busy9", {31'd0, busy9}, 32'd0);
        RST = 1'b1;
        tick;

        // 0xA5, no parity, prescale 16: 10 bits x 16 cycles
        tx_frame(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 6'd16);
        for (int n = 0; n < 6; n++)
            tx_frame(1'b0, 9'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rand_pre());

        rx_frame(8'h3C, 1'b1, 1'b0, 6'd8, 1'b0, 1'b1);
        rx_frame(8'h3C, 1'b1, 1'b0, 6'd8, 1'b1, 1'b1);
        rx_frame(8'h3C, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);

        // 3-cycle low glitch at prescale 16
        v0 = n_rxv + n_perr + n_ferr;
        Prescale = 6'd16;
        rx_drive = 1'b0;
        repeat (3) tick;
        rx_drive = 1'b1;
        repeat (30) tick;
        check("glitch_no_pulse", n_rxv + n_perr + n_ferr - v0, 32'd0);
        check("glitch_rx_idle", {29'd0, rxs8}, 32'd0);
        check("glitch_data_hold", {24'd0, rx_data8}, {24'd0, last_good});

        for (int n = 0; n < 8; n++) begin
            logic       pe  = 1'($urandom_range(0, 1));
            int         c   = $urandom_range(0, 2);
            rx_frame(8'($urandom), pe, 1'($urandom_range(0, 1)), rand_pre(), (c == 1) && pe, c != 2);
        end

        // 9-bit frame, two stop bits, reset during data bit 4
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1; tx_data = 9'h1FF;
        valid9 = 1'b1;
        tick;
        valid9 = 1'b0;
        repeat (16 * 5 + 3) tick;
        check("mid_frame_busy9", {31'd0, busy9}, 32'd1);
        check("mid_frame_tx9", {31'd0, tx_out9}, 32'd1);
        RST = 1'b0;
        tick;
        check("abort_tx_out9", {31'd0, tx_out9}, 32'd1);
        check("abort_busy9", {31'd0, busy9}, 32'd0);
        check("abort_tx_state9", {29'd0, txs9}, 32'd0);
        RST = 1'b1;
        last_good = 8'h00;
        tick;
        check("post_rst_idle9", {29'd0, txs9}, 32'd0);
        check("post_rst_rx_data", {24'd0, rx_data8}, 32'd0);
        tx_frame(1'b1, 9'h0A5, 1'b1, 1'b1, 1'b1, 6'd16);
        tx_frame(1'b1, 9'($urandom), 1'b1, 1'b0, 1'b0, 6'd8);

        // back-to-back loopback 0x55 then 0xAA at prescale 32
        v0 = n_rxv;
        loop_sel = 1'b1; Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        exp_q.push_back(9'h055);
        exp_q.push_back(9'h0AA);
        tx_data = 9'h055;
        valid8 = 1'b1;
        tick;
        tx_data = 9'h0AA;
        k = 0;
        while (busy8 !== 1'b0 && k < 1000) begin
            tick;
            k++;
        end
        check("lb_first_done", {31'd0, busy8}, 32'd0);
        tick;
        check("lb_restart", {31'd0, busy8}, 32'd1);
        valid8 = 1'b0;
        repeat (10 * 32 + 40) tick;
        check("lb_valid_count", n_rxv - v0, 32'd2);
        check("lb_scoreboard_drained", exp_q.size(), 32'd0);
        check("lb_rx_data", {24'd0, rx_data8}, 32'h0AA);
        loop_sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
